// File: rtl/maze_walker.sv
// Wall-follower maze solver: walks a square maze in external synchronous RAM,
// probing neighbours in left/right-hand order and marking every entered cell.
module maze_walker #(
    parameter int maze_width = 6,
    parameter int step_width = 16,
    parameter int max_steps  = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  hand,
    input  logic [1:0]            start_dir,
    input  logic [maze_width-1:0] starting_row,
    input  logic [maze_width-1:0] starting_col,
    input  logic                  maze_in,
    output logic [maze_width-1:0] row,
    output logic [maze_width-1:0] col,
    output logic                  maze_oe,
    output logic                  maze_we,
    output logic                  done,
    output logic                  fail,
    output logic [step_width-1:0] steps
);
    typedef enum logic [2:0] {IDLE, MARK, PROBE, EVAL, MOVE, DONE, FAIL} state_t;

    localparam logic [maze_width-1:0] ONE      = maze_width'(1);
    localparam logic [step_width-1:0] STEP_MAX = step_width'(max_steps);

    state_t                state, state_n;
    logic [maze_width-1:0] row_n, col_n, cur_row, cur_col, cur_row_n, cur_col_n;
    logic [1:0]            heading, heading_n, idx, idx_n, dir0, dir_next, dir_cur;
    logic                  hand_r, hand_n, oe_n, we_n, done_n, fail_n;
    logic [step_width-1:0] steps_n;

    // Candidate heading for probe i: left-hand tries h-1,h,h+1,h+2; right-hand h+1,h,h-1,h+2.
    function automatic logic [1:0] cand_dir(input logic [1:0] h, input logic [1:0] i, input logic rh);
        case (i)
            2'd0:    return rh ? h + 2'd1 : h + 2'd3;
            2'd1:    return h;
            2'd2:    return rh ? h + 2'd3 : h + 2'd1;
            default: return h + 2'd2;
        endcase
    endfunction

    function automatic logic [maze_width-1:0] step_row(input logic [maze_width-1:0] r, input logic [1:0] d);
        return (d == 2'd0) ? r - ONE : (d == 2'd2) ? r + ONE : r;
    endfunction

    function automatic logic [maze_width-1:0] step_col(input logic [maze_width-1:0] c, input logic [1:0] d);
        return (d == 2'd1) ? c + ONE : (d == 2'd3) ? c - ONE : c;
    endfunction

    function automatic logic on_border(input logic [maze_width-1:0] r, input logic [maze_width-1:0] c);
        return (r == '0) || (r == '1) || (c == '0) || (c == '1);
    endfunction

    assign dir0     = cand_dir(heading, 2'd0, hand_r);
    assign dir_cur  = cand_dir(heading, idx, hand_r);
    assign dir_next = cand_dir(heading, idx + 2'd1, hand_r);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            row     <= '0;
            col     <= '0;
            cur_row <= '0;
            cur_col <= '0;
            heading <= '0;
            idx     <= '0;
            hand_r  <= 1'b0;
            maze_oe <= 1'b0;
            maze_we <= 1'b0;
            done    <= 1'b0;
            fail    <= 1'b0;
            steps   <= '0;
        end else begin
            state   <= state_n;
            row     <= row_n;
            col     <= col_n;
            cur_row <= cur_row_n;
            cur_col <= cur_col_n;
            heading <= heading_n;
            idx     <= idx_n;
            hand_r  <= hand_n;
            maze_oe <= oe_n;
            maze_we <= we_n;
            done    <= done_n;
            fail    <= fail_n;
            steps   <= steps_n;
        end
    end

    // Next-state logic produces the values every output takes in the state being entered.
    always_comb begin
        state_n   = state;
        row_n     = row;
        col_n     = col;
        cur_row_n = cur_row;
        cur_col_n = cur_col;
        heading_n = heading;
        idx_n     = idx;
        hand_n    = hand_r;
        oe_n      = 1'b0;
        we_n      = 1'b0;
        done_n    = done;
        fail_n    = fail;
        steps_n   = steps;
        case (state)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    state_n   = MARK;
                    hand_n    = hand;
                    heading_n = start_dir;
                    cur_row_n = starting_row;
                    cur_col_n = starting_col;
                    row_n     = starting_row;
                    col_n     = starting_col;
                    we_n      = 1'b1;
                    done_n    = 1'b0;
                    fail_n    = 1'b0;
                    steps_n   = '0;
                end
            end
            MARK, MOVE: begin
                if (on_border(cur_row, cur_col)) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else if (state == MOVE && steps == STEP_MAX) begin
                    state_n = FAIL;
                    fail_n  = 1'b1;
                end else begin
                    state_n = PROBE;
                    idx_n   = 2'd0;
                    row_n   = step_row(cur_row, dir0);
                    col_n   = step_col(cur_col, dir0);
                    oe_n    = 1'b1;
                end
            end
            PROBE: state_n = EVAL;
            EVAL: begin
                if (maze_in) begin
                    if (idx == 2'd3) begin
                        state_n = FAIL;
                        fail_n  = 1'b1;
                    end else begin
                        state_n = PROBE;
                        idx_n   = idx + 2'd1;
                        row_n   = step_row(cur_row, dir_next);
                        col_n   = step_col(cur_col, dir_next);
                        oe_n    = 1'b1;
                    end
                end else begin
                    // Probe address is already the free neighbour, so row/col just hold.
                    state_n   = MOVE;
                    heading_n = dir_cur;
                    cur_row_n = row;
                    cur_col_n = col;
                    we_n      = 1'b1;
                    steps_n   = steps + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_maze_walker.sv
// Bench for maze_walker on an 8x8 maze: two instances (budget 100 and 2) checked
// against a cell-by-cell wall-follower reference walk.
module tb_maze_walker;
    localparam int MW = 3;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst, start, hand;
    logic [1:0]    start_dir;
    logic [MW-1:0] srow, scol;
    logic          min_a = 1'b0, min_b = 1'b0;
    logic [MW-1:0] row_a, col_a, row_b, col_b;
    logic          oe_a, we_a, done_a, fail_a, oe_b, we_b, done_b, fail_b;
    logic [SW-1:0] steps_a, steps_b;

    always #5 clk = ~clk;

    maze_walker #(.maze_width(MW), .step_width(SW), .max_steps(100)) dut (
        .clk(clk), .rst(rst), .start(start), .hand(hand), .start_dir(start_dir),
        .starting_row(srow), .starting_col(scol), .maze_in(min_a),
        .row(row_a), .col(col_a), .maze_oe(oe_a), .maze_we(we_a),
        .done(done_a), .fail(fail_a), .steps(steps_a));

    maze_walker #(.maze_width(MW), .step_width(SW), .max_steps(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .hand(hand), .start_dir(start_dir),
        .starting_row(srow), .starting_col(scol), .maze_in(min_b),
        .row(row_b), .col(col_b), .maze_oe(oe_b), .maze_we(we_b),
        .done(done_b), .fail(fail_b), .steps(steps_b));

    logic wall [8][8];

    // 1-cycle-latency RAM reads; marks do not alter wall content
    always @(posedge clk) begin
        if (oe_a) min_a <= wall[row_a][col_a];
        if (oe_b) min_b <= wall[row_b][col_b];
    end

    int got_oe_a[$], got_we_a[$], got_oe_b[$], got_we_b[$];
    always @(negedge clk) begin
        if (oe_a) got_oe_a.push_back(row_a * 8 + col_a);
        if (we_a) got_we_a.push_back(row_a * 8 + col_a);
        if (oe_b) got_oe_b.push_back(row_b * 8 + col_b);
        if (we_b) got_we_b.push_back(row_b * 8 + col_b);
    end

    int n_chk = 0, n_pass = 0;
    int exp_oe[$], exp_we[$];
    int e_done, e_fail, e_steps, e_row, e_col;
    int busy_a;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, required %0d", tag, obs, exp);
    endtask

    function automatic bit border(input int r, input int c);
        return r == 0 || r == 7 || c == 0 || c == 7;
    endfunction

    // Reference walk: follow the hand rule cell by cell, listing probed and entered cells.
    task automatic model(input int sr, input int sc, input int sd, input int hd, input int maxs);
        int r, c, h, d, nr, nc;
        bit found;
        int lofs[4], rofs[4], dr[4], dc[4];
        lofs = '{3, 0, 1, 2};
        rofs = '{1, 0, 3, 2};
        dr   = '{-1, 0, 1, 0};
        dc   = '{0, 1, 0, -1};
        exp_oe.delete(); exp_we.delete();
        e_done = 0; e_fail = 0; e_steps = 0;
        r = sr; c = sc; h = sd;
        exp_we.push_back(r * 8 + c);
        e_row = r; e_col = c;
        if (border(r, c)) begin e_done = 1; return; end
        forever begin
            found = 0;
            for (int k = 0; k < 4 && !found; k++) begin
                d  = (h + (hd != 0 ? rofs[k] : lofs[k])) % 4;
                nr = r + dr[d];
                nc = c + dc[d];
                exp_oe.push_back(nr * 8 + nc);
                e_row = nr; e_col = nc;
                if (!wall[nr][nc]) begin found = 1; h = d; r = nr; c = nc; end
            end
            if (!found) begin e_fail = 1; return; end
            e_steps++;
            exp_we.push_back(r * 8 + c);
            if (border(r, c)) begin e_done = 1; return; end
            if (e_steps == maxs) begin e_fail = 1; return; end
        end
    endtask

    task automatic check_inst(input string tag, input bit b);
        int go[$], gw[$];
        int mm;
        if (b) begin go = got_oe_b; gw = got_we_b; end
        else begin go = got_oe_a; gw = got_we_a; end
        chk({tag, ".done"},  b ? int'(done_b)  : int'(done_a),  e_done);
        chk({tag, ".fail"},  b ? int'(fail_b)  : int'(fail_a),  e_fail);
        chk({tag, ".steps"}, b ? int'(steps_b) : int'(steps_a), e_steps);
        chk({tag, ".row"},   b ? int'(row_b)   : int'(row_a),   e_row);
        chk({tag, ".col"},   b ? int'(col_b)   : int'(col_a),   e_col);
        chk({tag, ".n_oe"},  go.size(), exp_oe.size());
        chk({tag, ".n_we"},  gw.size(), exp_we.size());
        mm = 0;
        for (int i = 0; i < go.size() && i < exp_oe.size(); i++) if (go[i] != exp_oe[i]) mm++;
        chk({tag, ".oe_seq_mismatches"}, mm, 0);
        mm = 0;
        for (int i = 0; i < gw.size() && i < exp_we.size(); i++) if (gw[i] != exp_we[i]) mm++;
        chk({tag, ".we_seq_mismatches"}, mm, 0);
    endtask

    task automatic launch(input int sr, input int sc, input int sd, input int hd);
        @(negedge clk);
        got_oe_a.delete(); got_we_a.delete(); got_oe_b.delete(); got_we_b.delete();
        srow = MW'(sr); scol = MW'(sc); start_dir = 2'(sd); hand = hd[0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Launch a walk, optionally pulse start again mid-walk, wait for both, check both.
    task automatic run_walk(input string tag, input int sr, input int sc, input int sd,
                            input int hd, input int mid_start);
        int cyc;
        launch(sr, sc, sd, hd);
        cyc = 0; busy_a = 0;
        while (!((done_a | fail_a) && (done_b | fail_b)) && cyc < 3000) begin
            if (!(done_a | fail_a)) busy_a++;
            if (mid_start != 0 && cyc == mid_start) begin
                srow = '0; scol = '0; start = 1'b1;
            end else start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, ".finished_in_budget"}, int'(cyc < 3000), 1);
        model(sr, sc, sd, hd, 2);
        check_inst({tag, ".b"}, 1'b1);
        model(sr, sc, sd, hd, 100);
        check_inst({tag, ".a"}, 1'b0);
        chk({tag, ".a.cycles"}, busy_a, 1 + 2 * exp_oe.size() + e_steps);
    endtask

    task automatic fill(input bit v);
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) wall[r][c] = v;
    endtask

    task automatic corridor();
        fill(1'b1);
        for (int r = 0; r < 8; r++) wall[r][3] = 1'b0;
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; hand = 1'b0; start_dir = '0; srow = '0; scol = '0;
        fill(1'b1);
        repeat (2) @(negedge clk);
        chk("reset.row", int'(row_a), 0);
        chk("reset.col", int'(col_a), 0);
        chk("reset.oe_we", int'({oe_a, we_a}), 0);
        chk("reset.done_fail", int'({done_a, fail_a}), 0);
        chk("reset.steps", int'(steps_a), 0);
        rst = 1'b0;

        corridor();
        run_walk("corridor", 3, 3, 0, 0, 0);
        chk("corridor.done", int'(done_a), 1);
        chk("corridor.steps", int'(steps_a), 3);
        chk("budget.fail", int'(fail_b), 1);
        chk("budget.done", int'(done_b), 0);
        chk("budget.row", int'(row_b), 1);

        fill(1'b1);
        run_walk("boxed", 3, 3, 0, 0, 0);
        chk("boxed.fail", int'(fail_a), 1);
        chk("boxed.n_oe", got_oe_a.size(), 4);

        fill(1'b1);
        wall[3][2] = 1'b0; wall[3][4] = 1'b0; wall[3][3] = 1'b0;
        run_walk("hand0", 3, 3, 0, 0, 0);
        chk("hand0.first_move", got_we_a.size() > 1 ? got_we_a[1] : -1, 3 * 8 + 2);
        run_walk("hand1", 3, 3, 0, 1, 0);
        chk("hand1.first_move", got_we_a.size() > 1 ? got_we_a[1] : -1, 3 * 8 + 4);

        run_walk("border", 0, 5, 2, 0, 0);
        chk("border.done", int'(done_a), 1);
        chk("border.n_oe", got_oe_a.size(), 0);

        // abort during EVAL, then rerun with a stray mid-walk start
        corridor();
        launch(3, 3, 0, 0);
        cyc = 0;
        while (!oe_a && cyc < 50) begin @(negedge clk); cyc++; end
        chk("abort.saw_probe", int'(oe_a), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort.row_col", int'({row_a, col_a}), 0);
        chk("abort.oe_we", int'({oe_a, we_a}), 0);
        chk("abort.done_fail", int'({done_a, fail_a}), 0);
        chk("abort.steps", int'(steps_a), 0);
        rst = 1'b0;
        run_walk("restart", 3, 3, 0, 0, 4);
        chk("restart.done", int'(done_a), 1);
        chk("restart.steps", int'(steps_a), 3);

        for (int t = 0; t < 8; t++) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) wall[r][c] = ($urandom_range(99) < 35);
            run_walk($sformatf("rand%0d", t), int'($urandom_range(6, 1)), int'($urandom_range(6, 1)),
                     int'($urandom_range(3)), int'($urandom_range(1)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
